oven_controller: RTL

OVEN_CONTROLLER -- requirements
Module: oven_controller

---
 rtl/oven_pkg.sv | 14 +
 rtl/oven_time_reg.sv | 27 ++
 rtl/oven_controller.sv | 101 ++++++++++
 3 files changed

// File: rtl/oven_pkg.sv
// oven_pkg: shared state encodings, time width and default timing constants.
package oven_pkg;
  localparam int TW            = 13;
  localparam int MAX_SEC_DEF   = 5999;
  localparam int QUICK_SEC_DEF = 30;
  localparam int BEEP_SEC_DEF  = 3;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/oven_time_reg.sv
// oven_time_reg: remaining-time register with clear, load, decrement and saturating add.
module oven_time_reg
  import oven_pkg::*;
#(
  parameter int MAX_SEC = MAX_SEC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  input  logic [6:0]    add_val,
  output logic [TW-1:0] q
);
  localparam logic [TW:0] MAX_W = (TW+1)'(MAX_SEC);
  logic [TW-1:0] q_q, q_d;
  logic [TW:0]   sum;
  always_comb begin
    sum = {1'b0, q_q} - {{TW{1'b0}}, dec && q_q != '0} + {{(TW-6){1'b0}}, add_val};
    q_d = clr ? '0 : load ? load_val : sum > MAX_W ? MAX_W[TW-1:0] : sum[TW-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/oven_controller.sv
// oven_controller: microwave oven FSM with beep timer, driving the remaining-time register.
module oven_controller
  import oven_pkg::*;
#(
  parameter int MAX_SEC   = MAX_SEC_DEF,
  parameter int QUICK_SEC = QUICK_SEC_DEF,
  parameter int BEEP_SEC  = BEEP_SEC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwr,
  input  logic          tick_1hz,
  input  logic          key_start,
  input  logic          key_stop,
  input  logic          add_10s,
  input  logic          add_60s,
  input  logic          door_open,
  output logic [TW-1:0] remaining,
  output logic          heating,
  output logic          beep,
  output logic [2:0]    state
);
  localparam logic [7:0] BEEP_N = 8'(BEEP_SEC);
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       heating_q, beep_q;
  logic       clr, load, dec;
  logic [6:0] add_val;
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    clr     = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    add_val = '0;
    if (!pwr) begin
      state_d = IDLE;
      clr     = 1'b1;
    end else begin
      case (state_q)
        IDLE, SET, PAUSE:
          if (key_stop) begin
            state_d = IDLE;
            clr     = 1'b1;
          end else if (add_10s || add_60s) begin
            add_val = (add_10s ? 7'd10 : 7'd0) + (add_60s ? 7'd60 : 7'd0);
            state_d = state_q == IDLE ? SET : state_q;
          end else if (key_start && !door_open) begin
            if (state_q == IDLE && remaining == '0) begin
              load    = 1'b1;
              state_d = COOK;
            end else if (state_q != IDLE && remaining != '0) begin
              state_d = COOK;
            end
          end
        COOK:
          if (key_stop || door_open) begin
            state_d = PAUSE;
          end else begin
            dec     = tick_1hz;
            add_val = add_60s ? 7'd60 : 7'd0;
            // only a tick that empties the timer without a concurrent top-up finishes
            if (tick_1hz && !add_60s && remaining <= TW'(1)) state_d = DONE;
          end
        DONE:
          if (key_stop || door_open) state_d = IDLE;
          else if (tick_1hz && cnt_q + 8'd1 == BEEP_N) state_d = IDLE;
          else cnt_d = cnt_q + {7'd0, tick_1hz};
        default: begin
          state_d = IDLE;
          clr     = 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      heating_q <= 1'b0;
      beep_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      heating_q <= state_d == COOK;
      beep_q    <= state_d == DONE;
    end
  oven_time_reg #(.MAX_SEC(MAX_SEC)) u_time (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .load    (load),
    .load_val(TW'(QUICK_SEC)),
    .dec     (dec),
    .add_val (add_val),
    .q       (remaining)
  );
  assign state   = state_q;
  assign heating = heating_q;
  assign beep    = beep_q;
endmodule
